// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB-to-memory bridge slave.
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCESS   = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_RESP     = 2'd3
   } state_e;

   localparam int unsigned DEF_BUS_WIDTH    = 64;
   localparam int unsigned DEF_OFS_BITS     = 5;
   localparam logic [4:0]  DEF_RO_FLAGS_OFS = 5'h0C;
   localparam logic [4:0]  DEF_RO_SP_OFS    = 5'h10;

   function automatic int unsigned strb_width(input int unsigned bus_width);
      return bus_width / 8;
   endfunction

   // Counter only needs to reach timeout-1.
   function automatic int unsigned tmr_width(input int unsigned timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/apb_mem_bridge_slave_timer.sv
// Wait-state timer: counts cycles while enabled, flags expiry on the TIMEOUT-th cycle.
module apb_wait_timer
   import apb_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = tmr_width(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_mem_bridge_slave.sv
// APB slave bridging to a req/ack memory port with byte strobes, wait states,
// timeout, read-only offset protection and a saturating error counter.
module apb_mem_bridge_slave
   import apb_bridge_pkg::*;
#(
   parameter int unsigned         DATA_WIDTH    = 32,
   parameter int unsigned         BUS_WIDTH     = DEF_BUS_WIDTH,
   parameter int unsigned         ADDR_WIDTH    = 32,
   parameter int unsigned         OFS_BITS      = DEF_OFS_BITS,
   parameter logic [OFS_BITS-1:0] RO_FLAGS_OFS  = OFS_BITS'(DEF_RO_FLAGS_OFS),
   parameter logic [OFS_BITS-1:0] RO_SP_OFS     = OFS_BITS'(DEF_RO_SP_OFS),
   parameter int unsigned         TIMEOUT       = 16,
   parameter int unsigned         ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     psel_i,
   input  logic                     penable_i,
   input  logic                     pwrite_i,
   input  logic [BUS_WIDTH/8-1:0]   pstrb_i,
   input  logic [BUS_WIDTH-1:0]     pwdata_i,
   input  logic [ADDR_WIDTH-1:0]    paddr_i,
   output logic [BUS_WIDTH-1:0]     prdata_o,
   output logic                     pready_o,
   output logic                     pslverr_o,
   output logic                     busy_o,
   input  logic                     start_bit_i,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [ADDR_WIDTH-1:0]    mem_addr_o,
   output logic [BUS_WIDTH-1:0]     mem_wdata_o,
   output logic [BUS_WIDTH/8-1:0]   mem_be_o,
   input  logic                     mem_ack_i,
   input  logic [BUS_WIDTH-1:0]     mem_rdata_i,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

   localparam int unsigned STRB_W = strb_width(BUS_WIDTH);

   if ((BUS_WIDTH % 8 != 0) || (BUS_WIDTH / DATA_WIDTH < 1) || (TIMEOUT < 2)) begin : g_param_check
      $error("apb_mem_bridge_slave: illegal parameter combination");
   end

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic                     pwrite_q, pwrite_d;
   logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
   logic [STRB_W-1:0]        strb_q, strb_d;
   logic                     err_q, err_d;
   logic                     aband_q, aband_d;
   logic                     mem_req_q, mem_req_d;
   logic [STRB_W-1:0]        mem_be_q, mem_be_d;
   logic [BUS_WIDTH-1:0]     prdata_q, prdata_d;
   logic                     pslverr_q, pslverr_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                     tmr_clear;
   logic                     tmr_expired;
   logic                     ro_hit;

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (tmr_clear),
      .en_i      (state_q == ST_MEM_WAIT),
      .expired_o (tmr_expired)
   );

   assign ro_hit = (paddr_i[OFS_BITS-1:0] == RO_FLAGS_OFS) ||
                   (paddr_i[OFS_BITS-1:0] == RO_SP_OFS);

   // Next-state, capture and response decode.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pwrite_d  = pwrite_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      err_d     = err_q;
      aband_d   = aband_q;
      mem_req_d = mem_req_q;
      mem_be_d  = mem_be_q;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      err_cnt_d = err_cnt_q;
      tmr_clear = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (psel_i && !penable_i) begin
               addr_d   = paddr_i;
               pwrite_d = pwrite_i;
               wdata_d  = pwdata_i;
               strb_d   = pstrb_i;
               err_d    = start_bit_i || (!pwrite_i && (|pstrb_i)) || (pwrite_i && ro_hit);
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!psel_i) begin
               state_d = ST_IDLE;
            end else if (penable_i) begin
               if (err_q) begin
                  state_d   = ST_RESP;
                  pslverr_d = 1'b1;
               end else if (pwrite_q && (strb_q == '0)) begin
                  state_d = ST_RESP;
               end else begin
                  state_d   = ST_MEM_WAIT;
                  mem_req_d = 1'b1;
                  mem_be_d  = pwrite_q ? strb_q : '1;
                  aband_d   = 1'b0;
                  tmr_clear = 1'b1;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (!psel_i) begin
               aband_d = 1'b1;
            end
            // Ack wins over a coinciding timeout.
            if (mem_ack_i || tmr_expired) begin
               mem_req_d = 1'b0;
               if (aband_d) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_RESP;
                  pslverr_d = !mem_ack_i;
                  prdata_d  = (mem_ack_i && !pwrite_q) ? mem_rdata_i : '0;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (pslverr_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         pwrite_q  <= 1'b0;
         wdata_q   <= '0;
         strb_q    <= '0;
         err_q     <= 1'b0;
         aband_q   <= 1'b0;
         mem_req_q <= 1'b0;
         mem_be_q  <= '0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         pwrite_q  <= pwrite_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         err_q     <= err_d;
         aband_q   <= aband_d;
         mem_req_q <= mem_req_d;
         mem_be_q  <= mem_be_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pready_o    = (state_q == ST_RESP);
   assign busy_o      = (state_q != ST_IDLE);
   assign prdata_o    = prdata_q;
   assign pslverr_o   = pslverr_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = pwrite_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_be_o    = mem_be_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_apb_mem_bridge_slave.sv
// Randomized self-checking bench for apb_mem_bridge_slave against a transaction-level model.
module tb_apb_mem_bridge_slave;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite, start_bit;
   logic [7:0]  pstrb;
   logic [63:0] pwdata;
   logic [31:0] paddr;
   logic [63:0] prdata_o;
   logic        pready_o, pslverr_o, busy_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic        mem_ack;
   logic [63:0] mem_rdata;
   logic [7:0]  err_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_cnt = 0;

   logic [63:0] mem_exp [logic [31:0]];
   logic [63:0] dut_mem [logic [31:0]];

   always #5 clk = ~clk;

   apb_mem_bridge_slave dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .pstrb_i     (pstrb),
      .pwdata_i    (pwdata),
      .paddr_i     (paddr),
      .prdata_o    (prdata_o),
      .pready_o    (pready_o),
      .pslverr_o   (pslverr_o),
      .busy_o      (busy_o),
      .start_bit_i (start_bit),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .err_cnt_o   (err_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] init_word(input logic [31:0] a);
      return {a, ~a};
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] be);
      logic [63:0] w;
      w = old;
      for (int b = 0; b < 8; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
      return w;
   endfunction

   function automatic logic [63:0] model_read(input logic [31:0] a);
      return mem_exp.exists(a) ? mem_exp[a] : init_word(a);
   endfunction

   // One full APB transfer; ack_lat = request cycle on which memory acks (0 = never).
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] strb, input bit start, input int ack_lat,
                       input string tag);
      bit          exp_err, exp_mem, tmo, done;
      logic [63:0] exp_rd;
      int          req_cycles, exp_req;
      exp_err = start || (!wr && strb != 8'h00) ||
                (wr && (addr[4:0] == 5'h0C || addr[4:0] == 5'h10));
      exp_mem = !exp_err && !(wr && strb == 8'h00);
      tmo     = exp_mem && !(ack_lat >= 1 && ack_lat <= int'(TIMEOUT));
      exp_req = !exp_mem ? 0 : (tmo ? int'(TIMEOUT) : ack_lat);
      exp_rd  = (exp_mem && !tmo && !wr) ? model_read(addr) : 64'h0;
      if (exp_mem && !tmo && wr) mem_exp[addr] = merge(model_read(addr), wdata, strb);
      if (exp_err || tmo) exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;

      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
      pwdata = wdata; pstrb = strb; start_bit = start;
      @(posedge clk); #1;
      chk({tag, "/busy_access"}, 64'(busy_o), 64'd1);
      penable = 1'b1; start_bit = 1'b0;
      req_cycles = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_rdata = {$urandom, $urandom};
         if (mem_req_o) begin
            req_cycles++;
            if (req_cycles == 1) begin
               chk({tag, "/mem_we"}, 64'(mem_we_o), 64'(wr));
               chk({tag, "/mem_be"}, 64'(mem_be_o), wr ? 64'(strb) : 64'hFF);
               chk({tag, "/mem_addr"}, 64'(mem_addr_o), 64'(addr));
               if (wr) chk({tag, "/mem_wdata"}, mem_wdata_o, wdata);
            end
            if (req_cycles == ack_lat) begin
               mem_ack = 1'b1;
               if (mem_we_o) begin
                  dut_mem[mem_addr_o] = merge(dut_mem.exists(mem_addr_o) ? dut_mem[mem_addr_o]
                                              : init_word(mem_addr_o), mem_wdata_o, mem_be_o);
               end else begin
                  mem_rdata = dut_mem.exists(mem_addr_o) ? dut_mem[mem_addr_o]
                                                         : init_word(mem_addr_o);
               end
            end
         end
         if (pready_o) begin
            done = 1'b1;
            chk({tag, "/pslverr"}, 64'(pslverr_o), 64'(exp_err || tmo));
            chk({tag, "/prdata"}, prdata_o, exp_rd);
            chk({tag, "/req_cycles"}, 64'(req_cycles), 64'(exp_req));
            chk({tag, "/req_low"}, 64'(mem_req_o), 64'd0);
            chk({tag, "/err_cnt"}, 64'(err_cnt_o), 64'(exp_cnt));
         end
      end
      mem_ack = 1'b0;
      if (!done) chk({tag, "/pready_timeout"}, 64'd0, 64'd1);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk({tag, "/idle_pready"}, {pready_o, pslverr_o, busy_o}, 64'd0);
      chk({tag, "/idle_prdata"}, prdata_o, 64'h0);
   endtask

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; start_bit = 1'b0;
      pstrb = '0; pwdata = '0; paddr = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {pready_o, pslverr_o, busy_o, mem_req_o, mem_we_o}, 64'd0);
      chk("reset_data", prdata_o | mem_wdata_o | 64'(mem_addr_o) | 64'(mem_be_o), 64'd0);
      chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      mem_exp[32'h20] = 64'hDEAD_BEEF_0123_4567;
      dut_mem[32'h20] = 64'hDEAD_BEEF_0123_4567;
      xfer(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 4, "t1_read");
      xfer(1'b1, 32'h08, 64'h1111_2222_3333_4444, 8'h0F, 1'b0, 2, "t2_write");
      xfer(1'b0, 32'h08, 64'h0, 8'h00, 1'b0, 1, "t2_readback");
      xfer(1'b1, 32'h0C, 64'h5, 8'hFF, 1'b0, 1, "t3_ro_flags");
      xfer(1'b1, 32'h10, 64'h6, 8'hFF, 1'b0, 1, "t3_ro_sp");
      xfer(1'b0, 32'h28, 64'h0, 8'h01, 1'b0, 1, "t3_rd_strb");
      chk("t3_err_cnt", 64'(err_cnt_o), 64'd3);
      xfer(1'b0, 32'h30, 64'h0, 8'h00, 1'b0, 0, "t4_timeout");
      xfer(1'b0, 32'h30, 64'h0, 8'h00, 1'b0, int'(TIMEOUT), "t4_ack_last");
      xfer(1'b1, 32'h38, 64'h77, 8'h00, 1'b0, 1, "t4_zero_strb");

      for (int i = 0; i < 80; i++) begin
         bit          wr;
         logic [31:0] a;
         logic [7:0]  s;
         int          lat;
         wr  = 1'($urandom_range(0, 1));
         a   = 32'($urandom_range(0, 31)) << 2;
         s   = wr ? (($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom))
                  : (($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
         lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 17
                                           : int'($urandom_range(1, 5));
         if ($urandom_range(0, 11) == 0) lat = int'(TIMEOUT);
         xfer(wr, a, {$urandom, $urandom}, s, ($urandom_range(0, 15) == 0), lat, "rand");
      end

      xfer(1'b0, 32'h40, 64'h0, 8'h00, 1'b1, 1, "t5_start_bit");
      while (exp_cnt < 255) xfer(1'b1, 32'h10, 64'h0, 8'hFF, 1'b0, 1, "t5_fill");
      xfer(1'b1, 32'h0C, 64'h0, 8'hFF, 1'b0, 1, "t5_saturate");
      chk("t5_err_cnt_sat", 64'(err_cnt_o), 64'hFF);

      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h48; pstrb = 8'h00;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t6_req_before_rst", 64'(mem_req_o), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_ctrl", {pready_o, pslverr_o, busy_o, mem_req_o, mem_we_o}, 64'd0);
      chk("t6_async_cnt", 64'(err_cnt_o), 64'd0);
      chk("t6_async_data", prdata_o | 64'(mem_be_o) | 64'(mem_addr_o), 64'd0);
      exp_cnt = 0;
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      xfer(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 1, "t6_read");
      xfer(1'b1, 32'h20, 64'hABCD_EF01_2345_6789, 8'hF0, 1'b0, 3, "t6_write");
      xfer(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 2, "t6_readback");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
